// File: rtl/result_stream_packer_pkg.sv
// Shared types for the result stream packer: FSM states, pad marker and the
// buffered beat format (64-bit data plus end-of-run flag).
package pkg_resultPacker;

    typedef enum logic [2:0] {
        COLLECT,
        PAD,
        SUM,
        STATS,
        DONE
    } state_e;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

endpackage

// File: rtl/result_packer_fifo.sv
// Single-clock beat FIFO. Push is ignored when full, pop when empty; a full
// FIFO that pops only frees its slot for a push on the following cycle.
module result_packer_fifo
    import pkg_resultPacker::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  beat_t         push_beat_i,
    input  logic          pop_i,
    output beat_t         head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    beat_t           mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_beat_i;
    end

endmodule

// File: rtl/result_stream_packer.sv
// Packs 32-bit results two per 64-bit beat, then on run completion emits an
// optional pad beat, a result-count beat and the cycle-count beat (last).
module result_stream_packer
    import pkg_resultPacker::*;
#(
    parameter int DEPTH        = 8,
    parameter int QUIET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] result_data,
    input  logic        result_ready_to_return,
    output logic        result_ready_to_accept,
    input  logic [63:0] stats_data,
    input  logic        stats_ready_to_return,
    output logic        stats_ready_to_accept,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);

    state_e        state_q, state_d;
    logic [31:0]   half_q, half_d;
    logic          half_vld_q, half_vld_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [QW-1:0] quiet_q, quiet_d;

    logic          push;
    beat_t         push_beat;
    beat_t         head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          res_xfer;

    result_packer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_beat_i (push_beat),
        .pop_i       (out_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign result_ready_to_accept = (state_q == COLLECT) && (fifo_count < (AW+1)'(DEPTH));
    assign res_xfer = result_ready_to_return && result_ready_to_accept;

    // Data and last are masked while empty so idle outputs read as zero.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 64'd0 : head.data;
    assign out_last  = !fifo_empty && head.last;

    always_comb begin
        state_d               = state_q;
        half_d                = half_q;
        half_vld_d            = half_vld_q;
        cnt_d                 = cnt_q;
        quiet_d               = quiet_q;
        push                  = 1'b0;
        push_beat             = '0;
        stats_ready_to_accept = 1'b0;

        case (state_q)
            COLLECT: begin
                if (res_xfer) begin
                    cnt_d = cnt_q + 32'd1;
                    if (half_vld_q) begin
                        push           = 1'b1;
                        push_beat.data = {result_data, half_q};
                        half_vld_d     = 1'b0;
                    end else begin
                        half_d     = result_data;
                        half_vld_d = 1'b1;
                    end
                end
                if (result_ready_to_return)
                    quiet_d = '0;
                else if (stats_ready_to_return && quiet_q != QUIET_MAX)
                    quiet_d = quiet_q + 1'b1;
                // Decide on the post-accept half state so a word taken on the
                // exit cycle still gets padded.
                if (quiet_q == QUIET_MAX)
                    state_d = half_vld_d ? PAD : SUM;
            end
            PAD: begin
                if (!fifo_full) begin
                    push           = 1'b1;
                    push_beat.data = {PAD_WORD, half_q};
                    half_vld_d     = 1'b0;
                    state_d        = SUM;
                end
            end
            SUM: begin
                if (!fifo_full) begin
                    push           = 1'b1;
                    push_beat.data = {32'd0, cnt_q};
                    state_d        = STATS;
                end
            end
            STATS: begin
                stats_ready_to_accept = !fifo_full;
                if (stats_ready_to_return && !fifo_full) begin
                    push           = 1'b1;
                    push_beat.data = stats_data;
                    push_beat.last = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: ;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= COLLECT;
            half_q     <= '0;
            half_vld_q <= 1'b0;
            cnt_q      <= '0;
            quiet_q    <= '0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            cnt_q      <= cnt_d;
            quiet_q    <= quiet_d;
        end
    end

endmodule

// File: tb/tb_result_stream_packer.sv
// Randomized bench for result_stream_packer; expected beats come from a
// queue-based model of the packing/trailer rules applied to accepted words.
module tb_result_stream_packer;

    localparam int DEPTH = 8;
    localparam int QUIET = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] result_data = '0;
    logic        rrtr = 1'b0;
    logic        rrta;
    logic [63:0] stats_data = '0;
    logic        srtr = 1'b0;
    logic        srta;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;

    logic [31:0] sent_q[$];
    logic [31:0] acc_q[$];
    logic [64:0] out_q[$];
    bit          saw_last = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    result_stream_packer #(.DEPTH(DEPTH), .QUIET_CYCLES(QUIET)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .result_data            (result_data),
        .result_ready_to_return (rrtr),
        .result_ready_to_accept (rrta),
        .stats_data             (stats_data),
        .stats_ready_to_return  (srtr),
        .stats_ready_to_accept  (srta),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_last               (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: records handshakes and checks output stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                                 out_valid, out_data, out_last, prev_data, prev_last);
                    end
                end
                if (rrtr && rrta) acc_q.push_back(result_data);
                if (out_valid && out_ready) begin
                    out_q.push_back({out_last, out_data});
                    if (out_last) saw_last = 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(posedge clk); #1;
        resetn = 1'b0;
        rrtr   = 1'b0;
        srtr   = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sent_q.delete();
        acc_q.delete();
        out_q.delete();
        saw_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [31:0] w);
        sent_q.push_back(w);
        result_data = w;
        rrtr = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (rrta) begin
                @(posedge clk); #1;
                rrtr = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        rrtr = 1'b0;
        checks++; errors++;
        $display("FAIL send_timeout: word %h never accepted", w);
    endtask

    task automatic compare_model(input logic [63:0] s, input string name);
        logic [64:0] exp_q[$];
        logic [64:0] got;
        int n;
        checks++;
        if (acc_q.size() != sent_q.size()) begin
            errors++;
            $display("FAIL %s_accepted: got %0d words required %0d", name, acc_q.size(), sent_q.size());
        end
        for (int i = 0; i < sent_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== sent_q[i]) begin
                errors++;
                $display("FAIL %s_word%0d: got %h required %h", name, i, acc_q[i], sent_q[i]);
            end
        end
        n = sent_q.size();
        for (int i = 0; i + 1 < n; i += 2) exp_q.push_back({1'b0, sent_q[i+1], sent_q[i]});
        if (n % 2 == 1) exp_q.push_back({1'b0, 32'h8000_0000, sent_q[n-1]});
        exp_q.push_back({1'b0, 32'd0, 32'(n)});
        exp_q.push_back({1'b1, s});
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_beats: got %0d beats required %0d", name, out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got last=%0b data=%h required last=%0b data=%h",
                         name, i, got[64], got[63:0], exp_q[i][64], exp_q[i][63:0]);
            end
        end
    endtask

    task automatic finish_run(input logic [63:0] s, input string name);
        stats_data = s;
        srtr = 1'b1;
        for (int t = 0; t < 2000 && !saw_last; t++) @(negedge clk);
        checks++;
        if (!saw_last) begin
            errors++;
            $display("FAIL %s_last: got no last beat required one", name);
        end
        @(posedge clk); #1;
        srtr = 1'b0;
        compare_model(s, name);
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        if (out_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h required 0", out_data); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", out_last); end
        if (srta !== 1'b0) begin errors++; $display("FAIL rst_stats_acc: got %b required 0", srta); end
        if (rrta !== 1'b1) begin errors++; $display("FAIL rst_res_acc: got %b required 1", rrta); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        do_reset();
        ready_mode = 1;
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        finish_run(64'd500, "basic");
    endtask

    task automatic test_odd;
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 3; i++) send_word({1'b0, 31'($urandom)});
        finish_run({$urandom, $urandom}, "odd");
    endtask

    task automatic test_backpressure;
        do_reset();
        ready_mode = 0;
        for (int i = 0; i < 2 * DEPTH; i++) send_word({1'b0, 31'($urandom)});
        result_data = 32'h1234_5678;
        rrtr = 1'b1;
        idle(5);
        @(negedge clk);
        checks += 3;
        if (rrta !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b required 0", rrta); end
        if (acc_q.size() != 2 * DEPTH) begin
            errors++; $display("FAIL bp_count: got %0d required %0d", acc_q.size(), 2 * DEPTH);
        end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", out_valid); end
        @(posedge clk); #1;
        ready_mode = 2;
        send_word(32'h1234_5678);
        finish_run(64'hDEAD_BEEF_0000_0001, "backpressure");
    endtask

    task automatic test_quiet;
        logic [63:0] s;
        do_reset();
        ready_mode = 2;
        s = {$urandom, $urandom};
        stats_data = s;
        srtr = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) send_word({1'b0, 31'($urandom)});
        finish_run(s, "quiet");
    endtask

    task automatic test_midreset;
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 3; i++) send_word({1'b0, 31'($urandom)});
        do_reset();
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
        if (out_data !== 64'd0) begin errors++; $display("FAIL midrst_data: got %h required 0", out_data); end
        @(posedge clk); #1;
        send_word(32'd7);
        send_word(32'd8);
        finish_run(64'd99, "midreset");
    endtask

    task automatic test_zero;
        do_reset();
        ready_mode = 2;
        finish_run(64'd10, "zero");
        result_data = 32'h55;
        rrtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks += 2;
            if (rrta !== 1'b0) begin errors++; $display("FAIL done_res_acc: got %b required 0", rrta); end
            if (srta !== 1'b0) begin errors++; $display("FAIL done_stats_acc: got %b required 0", srta); end
            @(posedge clk); #1;
        end
        rrtr = 1'b0;
        checks++;
        if (acc_q.size() != 0) begin errors++; $display("FAIL done_words: got %0d required 0", acc_q.size()); end
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ready_mode = 2;
            n = $urandom_range(1, 25);
            for (int i = 0; i < n; i++) begin
                send_word({1'b0, 31'($urandom)});
                idle($urandom_range(0, 3));
            end
            finish_run({$urandom, $urandom}, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_backpressure();
        test_quiet();
        test_midreset();
        test_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
